// File: rtl/glyph_pkg.sv
// Shared pixel constants, FSM state type and the seven-segment map used by the digit glyph ROMs.
package glyph_pkg;

   localparam logic [5:0]  PIX_WHITE   = 6'h3F;
   localparam logic [5:0]  PIX_BLACK   = 6'h00;
   localparam int unsigned GLYPH_W_DEF = 8;
   localparam int unsigned GLYPH_H_DEF = 16;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

   typedef logic [3:0] bcd_t;

   // Lit segments as {a,b,c,d,e,f,g}; a = top bar, g = middle bar.
   function automatic logic [6:0] seg_of(input bcd_t v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/glyph_rom_mux.sv
// Ten combinational per-digit glyph ROMs (seven-segment style, black strokes on white)
// and the selector that picks one by BCD value, returning white for non-decimal codes.
module glyph_rom
   import glyph_pkg::*;
#(
   parameter int unsigned DIGIT   = 0,
   parameter int unsigned GLYPH_W = GLYPH_W_DEF,
   parameter int unsigned GLYPH_H = GLYPH_H_DEF
) (
   input  logic [4:0] col,
   input  logic [4:0] row,
   output logic [5:0] data
);

   localparam logic [4:0] LC = 5'd1;
   localparam logic [4:0] RC = 5'(GLYPH_W - 2);
   localparam logic [4:0] TR = 5'd1;
   localparam logic [4:0] MR = 5'(GLYPH_H / 2 - 1);
   localparam logic [4:0] BR = 5'(GLYPH_H - 2);
   localparam logic [6:0] SEG = seg_of(4'(DIGIT));

   logic hbar, upper, lower, on;

   // Strokes are one pixel wide, inset one pixel from the cell border.
   always_comb begin
      hbar  = (col >= LC) && (col <= RC);
      upper = (row >= TR) && (row <= MR);
      lower = (row >= MR) && (row <= BR);
      on    = (SEG[6] && row == TR && hbar) ||
              (SEG[5] && col == RC && upper) ||
              (SEG[4] && col == RC && lower) ||
              (SEG[3] && row == BR && hbar) ||
              (SEG[2] && col == LC && lower) ||
              (SEG[1] && col == LC && upper) ||
              (SEG[0] && row == MR && hbar);
      data  = on ? PIX_BLACK : PIX_WHITE;
   end

endmodule

module glyph_rom_mux
   import glyph_pkg::*;
#(
   parameter int unsigned GLYPH_W = GLYPH_W_DEF,
   parameter int unsigned GLYPH_H = GLYPH_H_DEF
) (
   input  bcd_t       digit,
   input  logic [4:0] col,
   input  logic [4:0] row,
   output logic [5:0] data
);

   logic [5:0] rom_data [10];

   for (genvar g = 0; g < 10; g++) begin : g_rom
      glyph_rom #(
         .DIGIT   (g),
         .GLYPH_W (GLYPH_W),
         .GLYPH_H (GLYPH_H)
      ) rom (
         .col  (col),
         .row  (row),
         .data (rom_data[g])
      );
   end

   always_comb begin
      data = PIX_WHITE;
      for (int i = 0; i < 10; i++) begin
         if (digit == 4'(i)) data = rom_data[i];
      end
   end

endmodule

// File: rtl/glyph_streamer.sv
// Scans a BCD readout through the glyph ROMs and streams pixels row-major over valid/ready,
// blanking leading zeros when enabled.
module glyph_streamer
   import glyph_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned GLYPH_W       = GLYPH_W_DEF,
   parameter int unsigned GLYPH_H       = GLYPH_H_DEF,
   parameter bit          BLANK_LEADING = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    pix_ready,
   output logic [5:0]              pix_data,
   output logic                    pix_valid,
   output logic                    pix_last,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned DW = $clog2(NUM_DIGITS) + 1;

   state_t                  state_q, state_d;
   logic [4:0]              col_q, row_q;
   logic [DW-1:0]           dig_q;
   bcd_t                    digit_q [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   blank_q, blank_c;
   logic                    seen_c;
   bcd_t                    cur_digit_c;
   logic                    cur_blank_c;
   logic [5:0]              rom_data_c, pix_c;
   logic                    load_c, accept_c, last_pos_c;

   // Leading-zero mask from the live input; captured together with the digits at start.
   always_comb begin
      seen_c  = 1'b0;
      blank_c = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (digits_in[4*(int'(NUM_DIGITS)-1-i) +: 4] != 4'd0) seen_c = 1'b1;
         blank_c[i] = BLANK_LEADING && !seen_c && (i != int'(NUM_DIGITS) - 1);
      end
   end

   always_comb begin
      cur_digit_c = '0;
      cur_blank_c = 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (dig_q == DW'(i)) begin
            cur_digit_c = digit_q[i];
            cur_blank_c = blank_q[i];
         end
      end
   end

   glyph_rom_mux #(
      .GLYPH_W (GLYPH_W),
      .GLYPH_H (GLYPH_H)
   ) u_rom (
      .digit (cur_digit_c),
      .col   (col_q),
      .row   (row_q),
      .data  (rom_data_c)
   );

   always_comb begin
      pix_c      = cur_blank_c ? PIX_WHITE : rom_data_c;
      accept_c   = pix_valid && pix_ready;
      load_c     = (state_q == STREAM) && (!pix_valid || pix_ready);
      last_pos_c = (row_q == 5'(GLYPH_H - 1)) && (dig_q == DW'(NUM_DIGITS - 1)) &&
                   (col_q == 5'(GLYPH_W - 1));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = STREAM;
         STREAM:  if (load_c && last_pos_c) state_d = DRAIN;
         DRAIN:   if (accept_c) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status flags track the state being entered so they line up with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_d == STREAM) || (state_d == DRAIN);
         done <= (state_d == DONE);
      end
   end

   // Frame capture, scan counters and the output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q     <= '0;
         row_q     <= '0;
         dig_q     <= '0;
         blank_q   <= '0;
         pix_data  <= '0;
         pix_valid <= 1'b0;
         pix_last  <= 1'b0;
         for (int i = 0; i < int'(NUM_DIGITS); i++) digit_q[i] <= '0;
      end else begin
         if (state_q == IDLE && start) begin
            col_q   <= '0;
            row_q   <= '0;
            dig_q   <= '0;
            blank_q <= blank_c;
            for (int i = 0; i < int'(NUM_DIGITS); i++)
               digit_q[i] <= digits_in[4*(int'(NUM_DIGITS)-1-i) +: 4];
         end
         if (load_c) begin
            pix_data  <= pix_c;
            pix_valid <= 1'b1;
            pix_last  <= last_pos_c;
            if (!last_pos_c) begin
               if (col_q == 5'(GLYPH_W - 1)) begin
                  col_q <= '0;
                  if (dig_q == DW'(NUM_DIGITS - 1)) begin
                     dig_q <= '0;
                     row_q <= row_q + 5'd1;
                  end else begin
                     dig_q <= dig_q + DW'(1);
                  end
               end else begin
                  col_q <= col_q + 5'd1;
               end
            end
         end else if (accept_c) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_glyph_streamer.sv
// Randomized bench for glyph_streamer: two instances (leading blanking on/off) against a
// pixel-index reference model built from a per-digit segment-letter table.
module tb_glyph_streamer;

   localparam int N    = 4;
   localparam int W    = 8;
   localparam int H    = 16;
   localparam int LINE = N * W;
   localparam int P    = LINE * H;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           start = 1'b0;
   logic           pix_ready = 1'b0;
   logic [4*N-1:0] digits_in = '0;
   logic [5:0]     pd0, pd1;
   logic           pv0, pv1, pl0, pl1, b0, b1, dn0, dn1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [5:0] cap0 [P];
   logic [5:0] cap1 [P];

   string segs_tab [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

   always #5 clk = ~clk;

   glyph_streamer #(.NUM_DIGITS(N), .GLYPH_W(W), .GLYPH_H(H), .BLANK_LEADING(1'b1)) dut0 (
      .clk(clk), .reset_n(reset_n), .start(start), .digits_in(digits_in),
      .pix_ready(pix_ready), .pix_data(pd0), .pix_valid(pv0), .pix_last(pl0),
      .busy(b0), .done(dn0));

   glyph_streamer #(.NUM_DIGITS(N), .GLYPH_W(W), .GLYPH_H(H), .BLANK_LEADING(1'b0)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start), .digits_in(digits_in),
      .pix_ready(pix_ready), .pix_data(pd1), .pix_valid(pv1), .pix_last(pl1),
      .busy(b1), .done(dn1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic bit has_seg(input string s, input byte c);
      for (int i = 0; i < s.len(); i++) if (s[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   // Expected pixel at a frame index, straight from the frame/blanking/glyph rules.
   function automatic logic [5:0] model_pix(input logic [15:0] dg, input bit bl, input int idx);
      int row, d, col, v;
      bit lead_zero, hbar, upper, lower, on;
      string s;
      row = idx / LINE;
      d   = (idx % LINE) / W;
      col = idx % W;
      v   = int'(dg[4*(N-1-d) +: 4]);
      lead_zero = 1'b1;
      for (int k = 0; k <= d; k++) if (dg[4*(N-1-k) +: 4] != 4'd0) lead_zero = 1'b0;
      if (bl && lead_zero && d != N-1) return 6'h3F;
      if (v > 9) return 6'h3F;
      s     = segs_tab[v];
      hbar  = col >= 1 && col <= W-2;
      upper = row >= 1 && row <= H/2-1;
      lower = row >= H/2-1 && row <= H-2;
      on = (has_seg(s, "a") && row == 1     && hbar) ||
           (has_seg(s, "g") && row == H/2-1 && hbar) ||
           (has_seg(s, "d") && row == H-2   && hbar) ||
           (has_seg(s, "f") && col == 1     && upper) ||
           (has_seg(s, "b") && col == W-2   && upper) ||
           (has_seg(s, "e") && col == 1     && lower) ||
           (has_seg(s, "c") && col == W-2   && lower);
      return on ? 6'h00 : 6'h3F;
   endfunction

   function automatic logic [15:0] rand_bcd();
      logic [15:0] r;
      for (int i = 0; i < N; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
      return r;
   endfunction

   // Count non-white pixels of one digit column band in a captured frame.
   function automatic int dark_in_digit(input int which, input int d);
      int n;
      n = 0;
      for (int i = 0; i < P; i++) begin
         if ((i % LINE) / W == d) begin
            if (which == 0 && cap0[i] != 6'h3F) n++;
            if (which == 1 && cap1[i] != 6'h3F) n++;
         end
      end
      return n;
   endfunction

   task automatic run_frame(input string name, input logic [15:0] dg, input bit rnd,
                            input int abort_at, input int change_at, input bit capture);
      int idx, cyc;
      bit stalled, fin, changed;
      logic [5:0] pd_prev;
      logic pl_prev;
      idx = 0; cyc = 0; stalled = 0; fin = 0; changed = 0;
      pd_prev = '0; pl_prev = 1'b0;
      @(negedge clk);
      digits_in = dg;
      start     = 1'b1;
      pix_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (!fin && cyc < 4000) begin
         if (stalled) begin
            chk({name, "_hold_valid"}, 32'(pv0), 32'd1);
            chk({name, "_hold_data"},  32'(pd0), 32'(pd_prev));
            chk({name, "_hold_last"},  32'(pl0), 32'(pl_prev));
         end
         if (idx == P) begin
            chk({name, "_done"},     32'(dn0), 32'd1);
            chk({name, "_busy_end"}, 32'(b0),  32'd0);
            fin = 1'b1;
         end else begin
            chk({name, "_busy"},   32'(b0),  32'd1);
            chk({name, "_done_lo"}, 32'(dn0), 32'd0);
            if (cyc == 0) chk({name, "_lat0"}, 32'(pv0), 32'd0);
            if (cyc == 1) chk({name, "_lat1"}, 32'(pv0), 32'd1);
            if (idx == abort_at) begin
               #2 reset_n = 1'b0;
               #1;
               chk({name, "_rst_data"},  32'(pd0), 32'd0);
               chk({name, "_rst_valid"}, 32'(pv0), 32'd0);
               chk({name, "_rst_last"},  32'(pl0), 32'd0);
               chk({name, "_rst_busy"},  32'(b0),  32'd0);
               chk({name, "_rst_done"},  32'(dn0), 32'd0);
               chk({name, "_rst_valid1"}, 32'(pv1), 32'd0);
               @(negedge clk);
               reset_n   = 1'b1;
               pix_ready = 1'b0;
               return;
            end
            if (idx == change_at && !changed) begin
               start     = 1'b1;
               digits_in = 16'($urandom);
               changed   = 1'b1;
            end else begin
               start = 1'b0;
            end
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pv0 && pix_ready) begin
               chk({name, "_pix0"},   32'(pd0), 32'(model_pix(dg, 1'b1, idx)));
               chk({name, "_pix1"},   32'(pd1), 32'(model_pix(dg, 1'b0, idx)));
               chk({name, "_valid1"}, 32'(pv1), 32'd1);
               chk({name, "_last"},   32'(pl0), 32'(idx == P-1));
               if (capture) begin
                  cap0[idx] = pd0;
                  cap1[idx] = pd1;
               end
               idx++;
            end
            stalled = pv0 && !pix_ready;
            pd_prev = pd0;
            pl_prev = pl0;
         end
         cyc++;
         if (!fin) @(negedge clk);
      end
      chk({name, "_finished"}, 32'(fin), 32'd1);
      chk({name, "_count"},    32'(idx), 32'(P));
      start     = 1'b0;
      pix_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_data",  32'(pd0), 32'd0);
      chk("reset_valid", 32'(pv0), 32'd0);
      chk("reset_last",  32'(pl0), 32'd0);
      chk("reset_busy",  32'(b0),  32'd0);
      chk("reset_done",  32'(dn0), 32'd0);
      reset_n = 1'b1;

      run_frame("t1_abort",   16'h0005, 1'b0, 100, -1, 1'b0);
      run_frame("t2_plain",   16'h0005, 1'b0, -1,  -1, 1'b1);
      chk("t2_idx56", 32'(cap0[56]), 32'h3F);
      for (int i = 57; i <= 62; i++) chk("t2_topbar", 32'(cap0[i]), 32'h00);
      chk("t2_idx63", 32'(cap0[63]), 32'h3F);
      for (int d = 0; d < 3; d++) chk("t2_blanked", 32'(dark_in_digit(0, d)), 32'd0);
      chk("t6_lead0_drawn", 32'(cap1[33]), 32'h00);

      run_frame("t3_stall",    16'h0005,   1'b1, -1, -1,  1'b0);
      run_frame("t4_midstart", rand_bcd(), 1'b1, -1, 200, 1'b0);

      run_frame("t5_zero", 16'h0000, 1'b1, -1, -1, 1'b1);
      for (int d = 0; d < 3; d++) chk("t5_zero_blank", 32'(dark_in_digit(0, d)), 32'd0);
      chk("t5_zero_drawn", 32'(cap0[LINE + 3*W + 1]), 32'h00);

      run_frame("t5_hex", 16'h1A05, 1'b1, -1, -1, 1'b1);
      chk("t5_hex_white0", 32'(dark_in_digit(0, 1)), 32'd0);
      chk("t5_hex_white1", 32'(dark_in_digit(1, 1)), 32'd0);

      for (int f = 0; f < 3; f++) run_frame("rand", 16'($urandom), 1'b1, -1, -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
